// File: rtl/activation_unit.sv
// activation_unit: multi-lane 3-stage pipelined fixed-point ReLU / ReLU6 / hard-sigmoid / hard-swish
// Ports:
//   clk, rst_n (async, active-low)
//   mode      2-bit function select, captured with each accepted beat
//   in_valid / in_ready / in_data    input beat handshake, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid / out_ready / out_data output beat handshake, same lane packing
// Build option: ACT_HSWISH_EN enables hard-sigmoid and hard-swish; otherwise modes 10/11 act as ReLU6
module activation_unit #(
   parameter int DATA_WIDTH = 14,
   parameter int FRAC_BITS  = 7,
   parameter int LANES      = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [1:0]                    mode,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES*DATA_WIDTH-1:0]   in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES*DATA_WIDTH-1:0]   out_data
);
   localparam int W        = DATA_WIDTH;
   localparam int F        = FRAC_BITS;
   localparam int INT_BITS = W - F;
   localparam logic signed [W:0] SIX      = (W+1)'(6 << F);
   localparam logic signed [W:0] RELU_MAX = (W+1)'(((1 << (INT_BITS-1)) - 1) << F);
`ifdef ACT_HSWISH_EN
   localparam logic signed [W:0]   THREE = (W+1)'(3 << F);
   localparam logic signed [2*W:0] HALF  = {{(2*W+1-F){1'b0}}, 1'b1, {(F-1){1'b0}}};
   localparam logic signed [2*W:0] YMAX  = {{(W+2){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [2*W:0] YMIN  = {{(W+2){1'b1}}, {(W-1){1'b0}}};
`endif

   function automatic logic [W-1:0] clamp(input logic signed [W:0] v, input logic signed [W:0] hi);
      return v[W] ? '0 : (v > hi) ? hi[W-1:0] : v[W-1:0];
   endfunction

   // Extended by one bit so x+THREE cannot wrap before clamping
   function automatic logic [W-1:0] stage1(input logic [W-1:0] x, input logic [1:0] m);
      logic signed [W:0] sx;
      sx = $signed({x[W-1], x});
`ifdef ACT_HSWISH_EN
      return m == 2'b00 ? clamp(sx, RELU_MAX) : m[1] ? clamp(sx + THREE, SIX) : clamp(sx, SIX);
`else
      return m == 2'b00 ? clamp(sx, RELU_MAX) : clamp(sx, SIX);
`endif
   endfunction

`ifdef ACT_HSWISH_EN
   // r is non-negative here, so an unsigned product with the 1/6 constant is exact
   function automatic logic [W-1:0] stage2(input logic [W-1:0] r, input logic sig);
      logic [W+16:0] rk;
      rk = {17'd0, r} * {{W{1'b0}}, 17'd10923} + {{(W+1){1'b0}}, 16'h8000};
      return sig ? rk[W+15:16] : r;
   endfunction

   function automatic logic [W-1:0] stage3(input logic [W-1:0] h, input logic [W-1:0] x, input logic [1:0] m);
      logic signed [2*W:0] xs, hs, y;
      xs = {{(W+1){x[W-1]}}, x};
      hs = {{(W+1){1'b0}}, h};
      y  = (xs * hs + HALF) >>> F;
      return m != 2'b11 ? h : y > YMAX ? YMAX[W-1:0] : y < YMIN ? YMIN[W-1:0] : y[W-1:0];
   endfunction
`endif

   logic           adv, v1, v2;
   logic [W-1:0]   d1 [LANES];
   logic [W-1:0]   d2 [LANES];
   logic [W-1:0]   d3 [LANES];
`ifdef ACT_HSWISH_EN
   logic [W-1:0]   x1 [LANES];
   logic [W-1:0]   x2 [LANES];
   logic [1:0]     m1, m2;
`endif

   // One global enable: the whole pipe freezes only when a valid output is held
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
`ifdef ACT_HSWISH_EN
         m1        <= '0;
         m2        <= '0;
`endif
         for (int i = 0; i < LANES; i++) begin
            d1[i] <= '0;
            d2[i] <= '0;
            d3[i] <= '0;
`ifdef ACT_HSWISH_EN
            x1[i] <= '0;
            x2[i] <= '0;
`endif
         end
      end else if (adv) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
`ifdef ACT_HSWISH_EN
         m1        <= mode;
         m2        <= m1;
`endif
         for (int i = 0; i < LANES; i++) begin
            d1[i] <= stage1(in_data[i*W +: W], mode);
`ifdef ACT_HSWISH_EN
            x1[i] <= in_data[i*W +: W];
            x2[i] <= x1[i];
            d2[i] <= stage2(d1[i], m1[1]);
            d3[i] <= stage3(d2[i], x2[i], m2);
`else
            d2[i] <= d1[i];
            d3[i] <= d2[i];
`endif
         end
      end

   for (genvar g = 0; g < LANES; g++) begin : g_out
      assign out_data[g*W +: W] = d3[g];
   end
endmodule
